// File: rtl/msrv32_rf_wr_arbiter.sv
// msrv32_rf_wr_arbiter
// Shares the single integer register-file write port between the in-order
// pipeline writeback and a multi-cycle unit (divider, late load, ...).
// MCU results wait in a small FIFO and are drained into write slots the
// pipeline leaves idle. If the FIFO head waits too long, a starvation timer
// raises stall_out so that the pipeline holds writeback and the head drains.
// The pipeline write request arrives already qualified by flush.
module msrv32_rf_wr_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        flush_in,
  input  logic        pipe_wr_en_in,
  input  logic [4:0]  pipe_rd_addr_in,
  input  logic [31:0] pipe_rd_data_in,
  input  logic        mcu_valid_in,
  input  logic [4:0]  mcu_rd_addr_in,
  input  logic [31:0] mcu_rd_data_in,
  output logic        mcu_ready_out,
  output logic        stall_out,
  output logic        mcu_busy_out,
  output logic        rf_wr_en_out,
  output logic [4:0]  rf_wr_addr_out,
  output logic [31:0] rf_wr_data_out
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  // Pointer advance with an explicit wrap at DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Starvation counter increment that holds at MAX_WAIT instead of wrapping.
  function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
    if (v == WAIT_W'(MAX_WAIT)) begin
      return v;
    end
    return v + WAIT_W'(1);
  endfunction

  // FIFO storage (data only, never reset)
  logic [4:0]        fifo_addr [DEPTH];
  logic [31:0]       fifo_data [DEPTH];

  // FIFO control
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              head_blocked;

  // Starvation FSM
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              stall_q;

  // Arbitration result
  logic              pipe_req;
  logic              win_vld;
  logic [4:0]        win_addr;
  logic [31:0]       win_data;

  // Registered write port
  logic              vld_p0;
  logic [4:0]        rf_wr_addr_p0;
  logic [31:0]       rf_wr_data_p0;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));

  assign mcu_ready_out = !fifo_full;
  assign mcu_busy_out  = !fifo_empty;
  assign stall_out     = stall_q;

  assign rf_wr_en_out   = vld_p0;
  assign rf_wr_addr_out = rf_wr_addr_p0;
  assign rf_wr_data_out = rf_wr_data_p0;

  // A stalled pipeline may not write; a flushed instruction never writes.
  assign pipe_req = pipe_wr_en_in & !flush_in & !stall_q;

  // Only the registered count is consulted, so a result pushed into an
  // empty FIFO becomes poppable one cycle later (no same-cycle bypass).
  assign push         = mcu_valid_in & !fifo_full;
  assign pop          = !fifo_empty & (stall_q | !pipe_req);
  assign head_blocked = !fifo_empty & !pop;

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Starvation FSM: track how long the head waits and force a drain.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        wait_nxt = '0;
        if (push) begin
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (count_nxt == '0) begin
          state_nxt = IDLE;
          wait_nxt  = '0;
        end else if (pop) begin
          wait_nxt  = '0;
        end else if (head_blocked) begin
          wait_nxt = wait_sat_inc(wait_cnt);
          if (wait_nxt == WAIT_W'(MAX_WAIT)) begin
            state_nxt = STALL;
          end
        end
      end
      STALL: begin
        wait_nxt = '0;
        if (count_nxt == '0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = PEND;
        end
      end
      default: begin
        state_nxt = IDLE;
        wait_nxt  = '0;
      end
    endcase
  end

  // Winner selection: a forced drain or an idle pipeline slot takes the head.
  always_comb begin
    win_vld  = 1'b0;
    win_addr = '0;
    win_data = '0;
    if (pop) begin
      win_vld  = 1'b1;
      win_addr = fifo_addr[rd_ptr];
      win_data = fifo_data[rd_ptr];
    end else if (pipe_req) begin
      win_vld  = 1'b1;
      win_addr = pipe_rd_addr_in;
      win_data = pipe_rd_data_in;
    end
  end

  // FSM, timer, stall flag and FIFO pointers; reset empties the FIFO at once.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state    <= IDLE;
      wait_cnt <= '0;
      stall_q  <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      stall_q  <= (state_nxt == STALL);
      count    <= count_nxt;
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // FIFO entry capture on push.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mcu_rd_addr_in;
      fifo_data[wr_ptr] <= mcu_rd_data_in;
    end
  end

  // ---- stage p0: registered register-file write port ----
  // Writes to x0 are consumed but never enabled.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      vld_p0        <= 1'b0;
      rf_wr_addr_p0 <= '0;
      rf_wr_data_p0 <= '0;
    end else begin
      vld_p0 <= win_vld & (win_addr != 5'd0);
      if (win_vld) begin
        rf_wr_addr_p0 <= win_addr;
        rf_wr_data_p0 <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_msrv32_rf_wr_arbiter.sv
// Directed bench for msrv32_rf_wr_arbiter (DEPTH=2, MAX_WAIT=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_msrv32_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        pipe_en = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        mcu_valid = 1'b0;
  logic [4:0]  mcu_rd = '0;
  logic [31:0] mcu_data = '0;
  logic        mcu_ready;
  logic        stall;
  logic        mcu_busy;
  logic        rf_en;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int checks = 0;
  int errors = 0;

  msrv32_rf_wr_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .flush_in             (flush),
    .pipe_wr_en_in        (pipe_en),
    .pipe_rd_addr_in      (pipe_rd),
    .pipe_rd_data_in      (pipe_data),
    .mcu_valid_in         (mcu_valid),
    .mcu_rd_addr_in       (mcu_rd),
    .mcu_rd_data_in       (mcu_data),
    .mcu_ready_out        (mcu_ready),
    .stall_out            (stall),
    .mcu_busy_out         (mcu_busy),
    .rf_wr_en_out         (rf_en),
    .rf_wr_addr_out       (rf_addr),
    .rf_wr_data_out       (rf_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_en", 32'(rf_en), 32'd0);
    chk("rst_addr", 32'(rf_addr), 32'd0);
    chk("rst_data", rf_data, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(mcu_busy), 32'd0);
    chk("rst_ready", 32'(mcu_ready), 32'd1);
    rst = 1'b0;
    step();

    // Plain pipeline write, then the same write flushed
    pipe_en = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hA5A5_A5A5;
    step();
    chk("pipe_en", 32'(rf_en), 32'd1);
    chk("pipe_addr", 32'(rf_addr), 32'd5);
    chk("pipe_data", rf_data, 32'hA5A5_A5A5);
    flush = 1'b1;
    step();
    chk("flush_en", 32'(rf_en), 32'd0);
    flush = 1'b0; pipe_en = 1'b0;
    step();
    chk("idle_en", 32'(rf_en), 32'd0);

    // Single MCU result into an idle port: written two cycles after push
    mcu_valid = 1'b1; mcu_rd = 5'd7; mcu_data = 32'h0000_1234;
    step();
    chk("mcu_busy_hi", 32'(mcu_busy), 32'd1);
    chk("mcu_no_bypass", 32'(rf_en), 32'd0);
    mcu_valid = 1'b0;
    step();
    chk("mcu_en", 32'(rf_en), 32'd1);
    chk("mcu_addr", 32'(rf_addr), 32'd7);
    chk("mcu_data", rf_data, 32'h0000_1234);
    chk("mcu_busy_lo", 32'(mcu_busy), 32'd0);
    step();
    chk("mcu_after_en", 32'(rf_en), 32'd0);

    // Starvation: pipe writes every cycle, head blocked 4 cycles then forced
    pipe_en = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h300;
    mcu_valid = 1'b1; mcu_rd = 5'd9; mcu_data = 32'h0000_BEEF;
    step();
    chk("starve_e0_addr", 32'(rf_addr), 32'd3);
    chk("starve_e0_stall", 32'(stall), 32'd0);
    mcu_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      pipe_data = 32'h300 + 32'(i);
      step();
      chk("starve_stall_lo", 32'(stall), 32'd0);
      chk("starve_pipe_data", rf_data, 32'h300 + 32'(i));
    end
    pipe_data = 32'h304;
    step();
    chk("starve_stall_hi", 32'(stall), 32'd1);
    chk("starve_e4_data", rf_data, 32'h304);
    pipe_data = 32'h305;
    step();
    chk("drain_addr", 32'(rf_addr), 32'd9);
    chk("drain_data", rf_data, 32'h0000_BEEF);
    chk("drain_stall_lo", 32'(stall), 32'd0);
    chk("drain_busy_lo", 32'(mcu_busy), 32'd0);
    step();
    chk("resume_addr", 32'(rf_addr), 32'd3);
    chk("resume_data", rf_data, 32'h305);
    pipe_en = 1'b0;
    step();
    chk("resume_idle", 32'(rf_en), 32'd0);

    // Fill the FIFO, hold a third push, then push and pop in one cycle
    pipe_en = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h400;
    mcu_valid = 1'b1; mcu_rd = 5'd10; mcu_data = 32'hA;
    step();
    chk("fill1_ready", 32'(mcu_ready), 32'd1);
    mcu_rd = 5'd11; mcu_data = 32'hB;
    step();
    chk("full_ready", 32'(mcu_ready), 32'd0);
    mcu_rd = 5'd12; mcu_data = 32'hC;
    step();
    chk("full_ready_e2", 32'(mcu_ready), 32'd0);
    chk("full_stall_e2", 32'(stall), 32'd0);
    step();
    step();
    chk("full_stall_e4", 32'(stall), 32'd1);
    chk("full_ready_e4", 32'(mcu_ready), 32'd0);
    step();
    chk("full_pop_a_addr", 32'(rf_addr), 32'd10);
    chk("full_pop_a_data", rf_data, 32'hA);
    chk("full_pop_ready", 32'(mcu_ready), 32'd1);
    chk("full_pop_busy", 32'(mcu_busy), 32'd1);
    pipe_en = 1'b0;
    step();
    chk("pushpop_addr", 32'(rf_addr), 32'd11);
    chk("pushpop_data", rf_data, 32'hB);
    chk("pushpop_busy", 32'(mcu_busy), 32'd1);
    chk("pushpop_ready", 32'(mcu_ready), 32'd1);
    mcu_valid = 1'b0;
    step();
    chk("held_c_addr", 32'(rf_addr), 32'd12);
    chk("held_c_data", rf_data, 32'hC);
    chk("held_c_busy", 32'(mcu_busy), 32'd0);

    // Writes to x0 are consumed without enabling the register file
    mcu_valid = 1'b1; mcu_rd = 5'd0; mcu_data = 32'hDEAD;
    step();
    chk("x0_mcu_busy", 32'(mcu_busy), 32'd1);
    mcu_valid = 1'b0;
    step();
    chk("x0_mcu_en", 32'(rf_en), 32'd0);
    chk("x0_mcu_consumed", 32'(mcu_busy), 32'd0);
    pipe_en = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFACE;
    step();
    chk("x0_pipe_en", 32'(rf_en), 32'd0);
    mcu_valid = 1'b1; mcu_rd = 5'd0; mcu_data = 32'hD00D;
    step();
    chk("x0_both_en", 32'(rf_en), 32'd0);
    mcu_valid = 1'b0; pipe_en = 1'b0;
    step();
    chk("x0_drain_en", 32'(rf_en), 32'd0);
    chk("x0_drain_busy", 32'(mcu_busy), 32'd0);

    // Asynchronous reset in the middle of a drain with two entries queued
    pipe_en = 1'b1; pipe_rd = 5'd6; pipe_data = 32'h600;
    mcu_valid = 1'b1; mcu_rd = 5'd13; mcu_data = 32'hD;
    step();
    mcu_rd = 5'd14; mcu_data = 32'hE;
    step();
    chk("pre_rst_ready", 32'(mcu_ready), 32'd0);
    chk("pre_rst_en", 32'(rf_en), 32'd1);
    mcu_valid = 1'b0; pipe_en = 1'b0;
    step();
    chk("pre_rst_drain_addr", 32'(rf_addr), 32'd13);
    chk("pre_rst_drain_busy", 32'(mcu_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_en", 32'(rf_en), 32'd0);
    chk("async_rst_busy", 32'(mcu_busy), 32'd0);
    chk("async_rst_ready", 32'(mcu_ready), 32'd1);
    chk("async_rst_stall", 32'(stall), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_en1", 32'(rf_en), 32'd0);
    step();
    chk("post_rst_en2", 32'(rf_en), 32'd0);
    chk("post_rst_busy", 32'(mcu_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
